// File: rtl/spi_regbank_pkg.sv
// Shared types and constants for the SPI register bank.
package spi_regbank_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } state_e;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  // Width of a counter holding the values 0..n-1.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_regbank_if.sv
// SPI pin bundle: the controller drives the master side, the register bank sits on the slave side.
interface spi_regbank_if;

  logic sCLK;
  logic nCS;
  logic COPI;
  logic CIPO;
  logic cipo_oe;

  modport master (
    output sCLK,
    output nCS,
    output COPI,
    input  CIPO,
    input  cipo_oe
  );

  modport slave (
    input  sCLK,
    input  nCS,
    input  COPI,
    output CIPO,
    output cipo_oe
  );

endinterface

// File: rtl/spi_regbank_sync_edge.sv
// Two-flop synchroniser plus a history flop; rise/fall are combinational compares of the
// synchronised level against its history.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o,
  output logic rise_c_o,
  output logic fall_c_o
);

  logic [2:0] sync_q;
  logic [2:0] sync_d;

  assign sync_d = {sync_q[1:0], d_i};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {3{RST_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o      = sync_q[1];
  assign rise_c_o = sync_q[1] & ~sync_q[2];
  assign fall_c_o = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_regbank.sv
// SPI mode-0 peripheral with a NUM_REGS x DATA_W register bank and auto-incrementing bursts.
// Readback on CIPO is compiled in only when SPI_READBACK_EN is defined.
module spi_regbank
  import spi_regbank_pkg::*;
#(
  parameter int unsigned NUM_REGS = 5,
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned DATA_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  spi_regbank_if.slave               spi,
  output logic [NUM_REGS*DATA_W-1:0] regs_out,
  output logic [NUM_REGS-1:0]        wr_strobe,
  output logic                       frame_err
);

  localparam int unsigned CMD_W   = 1 + ADDR_W;
  localparam int unsigned SHIFT_W = (CMD_W > DATA_W) ? CMD_W : DATA_W;
  localparam int unsigned CNT_W   = cnt_w(SHIFT_W);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic ncs_lvl, ncs_rise, ncs_fall;
  logic copi_lvl, copi_rise, copi_fall;

  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
    .clk      (clk),
    .rst      (rst),
    .d_i      (spi.sCLK),
    .q_o      (sclk_lvl),
    .rise_c_o (sclk_rise),
    .fall_c_o (sclk_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_sync_ncs (
    .clk      (clk),
    .rst      (rst),
    .d_i      (spi.nCS),
    .q_o      (ncs_lvl),
    .rise_c_o (ncs_rise),
    .fall_c_o (ncs_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_copi (
    .clk      (clk),
    .rst      (rst),
    .d_i      (spi.COPI),
    .q_o      (copi_lvl),
    .rise_c_o (copi_rise),
    .fall_c_o (copi_fall)
  );

  state_e                             state_q, state_d;
  logic [CNT_W-1:0]                   bit_cnt_q, bit_cnt_d;
  logic [SHIFT_W-1:0]                 shift_q, shift_d;
  logic                               rw_q, rw_d;
  logic [ADDR_W-1:0]                  addr_q, addr_d;
  logic [NUM_REGS-1:0][DATA_W-1:0]    regs_q, regs_d;
  logic [NUM_REGS-1:0]                wr_strobe_q, wr_strobe_d;
  logic                               frame_err_q, frame_err_d;
  logic [1:0]                         settle_q, settle_d;
  logic                               armed_q, armed_d;

  logic [SHIFT_W-1:0] shift_in;
  logic [DATA_W-1:0]  word_in;
  logic               sample;

`ifdef SPI_READBACK_EN
  logic [DATA_W-1:0] tx_q, tx_d;
  logic              cipo_oe_q, cipo_oe_d;
  logic              pend_q, pend_d;

  function automatic logic [DATA_W-1:0] rd_word(input logic [NUM_REGS-1:0][DATA_W-1:0] r,
                                                input logic [ADDR_W-1:0]             a);
    rd_word = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (a == ADDR_W'(i)) rd_word = r[i];
    end
  endfunction
`endif

  assign shift_in = {shift_q[SHIFT_W-2:0], copi_lvl};
  assign word_in  = shift_in[DATA_W-1:0];
  assign sample   = sclk_rise & ~ncs_lvl;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rw_q        <= RW_WRITE;
      addr_q      <= '0;
      regs_q      <= '0;
      wr_strobe_q <= '0;
      frame_err_q <= 1'b0;
      settle_q    <= '0;
      armed_q     <= 1'b0;
`ifdef SPI_READBACK_EN
      tx_q        <= '0;
      cipo_oe_q   <= 1'b0;
      pend_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      regs_q      <= regs_d;
      wr_strobe_q <= wr_strobe_d;
      frame_err_q <= frame_err_d;
      settle_q    <= settle_d;
      armed_q     <= armed_d;
`ifdef SPI_READBACK_EN
      tx_q        <= tx_d;
      cipo_oe_q   <= cipo_oe_d;
      pend_q      <= pend_d;
`endif
    end
  end

  // Frame parser: next state, register writes, strobes and readback shifting.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    regs_d      = regs_q;
    wr_strobe_d = '0;
    frame_err_d = 1'b0;
    settle_d    = (settle_q == 2'd3) ? 2'd3 : settle_q + 2'd1;
    // A frame may only start from an nCS high seen after the synchronisers settle post-reset,
    // so a chip select held low across reset cannot fake a falling edge.
    armed_d     = armed_q | ((settle_q == 2'd3) & ncs_lvl);
`ifdef SPI_READBACK_EN
    tx_d        = tx_q;
    cipo_oe_d   = cipo_oe_q;
    pend_d      = pend_q;
`endif

    if (ncs_rise) begin
      if ((state_q == CMD) || ((state_q == DATA) && (bit_cnt_q != '0))) begin
        frame_err_d = 1'b1;
      end
      state_d   = IDLE;
      bit_cnt_d = '0;
`ifdef SPI_READBACK_EN
      tx_d      = '0;
      cipo_oe_d = 1'b0;
      pend_d    = 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ncs_fall && armed_q) begin
            state_d   = CMD;
            bit_cnt_d = '0;
            shift_d   = '0;
          end
        end

        CMD: begin
          if (sample) begin
            shift_d   = shift_in;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == CNT_W'(CMD_W - 1)) begin
              rw_d      = shift_in[CMD_W-1];
              addr_d    = shift_in[ADDR_W-1:0];
              bit_cnt_d = '0;
              state_d   = DATA;
`ifdef SPI_READBACK_EN
              tx_d      = (rw_d == RW_READ) ? rd_word(regs_q, addr_d) : '0;
              cipo_oe_d = (rw_d == RW_READ);
              pend_d    = 1'b0;
`endif
            end
          end
        end

        DATA: begin
          if (sample) begin
            shift_d   = shift_in;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
              bit_cnt_d = '0;
              if (rw_q == RW_WRITE) begin
                for (int unsigned i = 0; i < NUM_REGS; i++) begin
                  if (addr_q == ADDR_W'(i)) begin
                    regs_d[i]      = word_in;
                    wr_strobe_d[i] = 1'b1;
                  end
                end
                addr_d = addr_q + ADDR_W'(1);
              end
            end
`ifdef SPI_READBACK_EN
            pend_d = (rw_q == RW_READ);
`endif
          end
`ifdef SPI_READBACK_EN
          // The falling edge after a sampled bit moves CIPO on; after a full word it fetches the next address.
          else if (sclk_fall && pend_q) begin
            pend_d = 1'b0;
            if (bit_cnt_q == '0) begin
              addr_d = addr_q + ADDR_W'(1);
              tx_d   = rd_word(regs_q, addr_d);
            end else begin
              tx_d = {tx_q[DATA_W-2:0], 1'b0};
            end
          end
`endif
        end

        default: state_d = IDLE;
      endcase
    end
  end

  assign regs_out  = regs_q;
  assign wr_strobe = wr_strobe_q;
  assign frame_err = frame_err_q;

`ifdef SPI_READBACK_EN
  assign spi.CIPO    = tx_q[DATA_W-1];
  assign spi.cipo_oe = cipo_oe_q;
`else
  assign spi.CIPO    = 1'b0;
  assign spi.cipo_oe = 1'b0;
`endif

  logic unused_sigs;
  assign unused_sigs = ^{sclk_lvl, sclk_fall, copi_rise, copi_fall, shift_q[SHIFT_W-1]};

endmodule

// File: doc/spi_regbank.md
# spi_regbank

Parametrised SPI (mode 0) peripheral with a register bank, readback and burst support. It is the next generation of the fixed five-register, write-only SPI peripheral. The block sits between the chip's SPI pins and the configuration registers that feed the output-enable and PWM logic. It exposes NUM_REGS registers of DATA_W bits and auto-increments the address across multi-word frames. When compiled in, it shifts register contents back out on CIPO.

## Interface
Parameters:
- NUM_REGS, 5: number of implemented registers at addresses 0..NUM_REGS-1.
- ADDR_W, 7: address field width in the command header.
- DATA_W, 8: bits per register and per data word.

Ports:
- clk  in  1  fast system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- sCLK  in  1  SPI clock; asynchronous to clk.
- nCS  in  1  SPI chip select, active low; asynchronous.
- COPI  in  1  controller-out data; asynchronous.
- CIPO  out  1  peripheral-out data.
- cipo_oe  out  1  high while the block is driving read data.
- regs_out  out  NUM_REGS*DATA_W  flattened register contents; register i occupies bits [i*DATA_W +: DATA_W].
- wr_strobe  out  NUM_REGS  one-clk pulse on the bit of each register written.
- frame_err  out  1  one-clk pulse when a frame ends mid-word.

## Operation
- Synchronisation: sCLK, nCS and COPI each pass through a 2-FF synchroniser plus one history flop. Edges are detected on the synchronised signals. nCS history resets to 1; the others reset to 0.
- Frame format: MSB first.
  - Bit 0 is rw: 1 = write, 0 = read.
  - The next ADDR_W bits are the start address.
  - Then 0..N words of DATA_W bits each.
- COPI is sampled on rising sCLK edges while synchronised nCS is low.
- States:
  - IDLE: leaves on an nCS falling edge, clearing the bit counter and the shift register, and goes to CMD.
  - CMD: shifts in 1+ADDR_W bits, then goes to DATA.
  - DATA: collects words. Returns to IDLE on an nCS rising edge from any state.
- Write: when a word's final bit is sampled:
  - if address < NUM_REGS, regs[address] takes the word and wr_strobe[address] pulses;
  - otherwise the word is silently dropped.
  - After each word, the address increments modulo 2^ADDR_W and the word counter clears.
- Partial words: an nCS rising edge with 1..DATA_W-1 data bits pending discards them and pulses frame_err. Fully received words of that frame remain committed. A frame ending inside CMD also pulses frame_err.
- Read (SPI_READBACK_EN):
  - On the cycle the last address bit is sampled, the shift register loads regs[address], or zero if the address is out of range.
  - CIPO then presents the MSB, and cipo_oe rises.
  - CIPO advances one bit on each falling sCLK edge.
  - After DATA_W bits, the next address is loaded and the address increments.
  - COPI data bits are ignored during reads.
- Reset: all of regs_out is 0 and state is IDLE. CIPO, cipo_oe, wr_strobe and frame_err are all 0.
  - rst asserted mid-frame aborts the frame with no commit.
  - After rst deasserts, no bits are accepted until a fresh nCS falling edge.

## Timing
- Write latency: regs_out updates on the clk edge after the final sCLK rising edge is detected. This is at most 4 clk cycles from the pin edge.
- wr_strobe is coincident with the regs_out update.
- Read launch: CIPO is valid at most 4 clk cycles after the pin edge that triggers the change (the last address bit's rising sCLK edge, or each falling sCLK edge).
- Required ratio: sCLK high and low phases are each at least 5 clk cycles. At minimum ratio, CIPO is stable before the controller's next rising edge.
- An nCS falling edge coincident with an sCLK rising edge: the sCLK edge is ignored. The first bit is the next rising edge.
- Back-to-back frames need at least 3 clk cycles of nCS high.

## Configuration
- SPI_READBACK_EN defined: read frames operate as described.
- SPI_READBACK_EN undefined:
  - CIPO and cipo_oe are tied to 0 and the read shift logic is absent.
  - Read frames are parsed and ignored, with no writes and no strobes.
  - frame_err behaves the same in both builds.

## Structure
- Package spi_regbank_pkg holds:
  - the state enum (IDLE, CMD, DATA);
  - the rw encoding constants (RW_WRITE=1, RW_READ=0);
  - a bit-count width helper function.
- Sub-module spi_sync_edge is a 2-FF synchroniser with rise and fall outputs and a parameterised reset value. It is instantiated once each for sCLK, nCS and COPI.

## Test plan
- Single write, default params: rw=1, addr 0x04, data 0xA5. Expect regs[4]=0xA5, one wr_strobe[4] pulse, all other registers 0.
- Burst write from addr 0x00 of 0x11, 0x22, 0x33. Expect regs[0..2]=0x11, 0x22, 0x33, three strobes in order, regs[3..4] unchanged.
- Out-of-range write to addr 0x07 with data 0xFF. Expect no register change and no strobe. Burst from 0x04 with 0xAA, 0xBB gives regs[4]=0xAA only.
- Partial frame: addr 0x01, 0x5C full, then 5 bits, then nCS high. Expect regs[1]=0x5C, regs[2] unchanged, one frame_err pulse.
- Readback (macro on): write regs[2]=0x3C, then burst-read from addr 0x02 for three words. CIPO returns 0x3C, regs[3], 0x00 MSB-first, with cipo_oe high only during the read data phase.
- rst pulsed mid-write at data bit 4. Expect all registers 0. The remaining bits of that frame are ignored until the next nCS falling edge.
